credit_vc_tx_port: RTL and testbench

Output-side credit manager and virtual-channel (VC) arbiter for one switch port.
- Accepts per-VC valid/data/backpressure (DVR) flit streams, tracks downstream credits per VC, and emits one registered flit per cycle with a one-hot VC target.
- Parametrised successor to the fixed per-port output path of the credit pi switch, with these added capabilities:
  - generalised VC count and credit depth;
  - selectable static or round-robin VC arbitration;
  - optional packet-atomic VC locking;
  - credit-overflow error detection.
- Sits between the switch crossbar and the noc_if transmitter (credit_packet, credit_vc_target, credit_vc_credit_gnt).

---
 rtl/credit_vc_tx_port_pkg.sv | 24 ++
 rtl/credit_vc_tx_port_counter.sv | 30 +++
 rtl/credit_vc_tx_port.sv | 133 +++++++++++++
 tb/tb_credit_vc_tx_port.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_vc_tx_port_pkg.sv
// Shared definitions for the credit-based VC transmit port:
// flit field layout helpers and credit counter sizing.
package credit_vc_tx_port_pkg;

    localparam int DEFAULT_A_W = 8;
    localparam int DEFAULT_D_W = 16;

    function automatic int flit_w(int a_w, int d_w);
        return a_w + d_w + 1;
    endfunction

    function automatic int last_pos(int a_w, int d_w);
        return a_w + d_w;
    endfunction

    function automatic int addr_lsb(int d_w);
        return d_w;
    endfunction

    function automatic int cnt_w(int credits);
        return (credits < 1) ? 1 : $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/credit_vc_tx_port_counter.sv
// Single-VC credit counter: decrements on send, increments on return,
// saturates at the initial credit value and flags overflow stickily.
module credit_vc_counter #(
    parameter int CREDITS = 3,
    parameter int CW      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          send,
    input  logic          ret,
    output logic [CW-1:0] cnt,
    output logic          ovf
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= CW'(CREDITS);
            ovf <= 1'b0;
        end else if (send && !ret) begin
            if (cnt != '0)
                cnt <= cnt - 1'b1;
        end else if (ret && !send) begin
            if (cnt == CW'(CREDITS))
                ovf <= 1'b1;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/credit_vc_tx_port.sv
// Output-side credit manager and VC arbiter for one switch port:
// per-VC credit tracking, static/round-robin arbitration, packet lock.
module credit_vc_tx_port
    import credit_vc_tx_port_pkg::*;
#(
    parameter int VC_W        = 2,
    parameter int A_W         = DEFAULT_A_W,
    parameter int D_W         = DEFAULT_D_W,
    parameter int CREDITS     = 3,
    parameter int FAIR_VC_ARB = 0,
    parameter int PKT_LOCK    = 1,
    localparam int FW         = flit_w(A_W, D_W),
    localparam int CW         = cnt_w(CREDITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [VC_W-1:0]      i_v,
    input  logic [VC_W*FW-1:0]   i_d,
    output logic [VC_W-1:0]      i_b,
    output logic [VC_W-1:0]      o_v,
    output logic [FW-1:0]        o_d,
    input  logic [VC_W-1:0]      credit_gnt,
    output logic [VC_W*CW-1:0]   credit_cnt,
    output logic                 err_ovf
);

    localparam int VIW = (VC_W > 1) ? $clog2(VC_W) : 1;
    localparam int LP  = last_pos(A_W, D_W);

    logic [VC_W-1:0] elig;
    logic [VC_W-1:0] send;
    logic [VC_W-1:0] ovf;
    logic            locked;
    logic [VIW-1:0]  lock_vc;
    logic [VIW-1:0]  ptr;
    logic            st_v, rr_v, gnt;
    logic [VIW-1:0]  st_g, rr_g, g;
    logic [FW-1:0]   flit;
    logic            flit_last;

    for (genvar k = 0; k < VC_W; k++) begin : g_vc
        assign elig[k] = i_v[k] & (|credit_cnt[k*CW +: CW]);

        credit_vc_counter #(
            .CREDITS (CREDITS),
            .CW      (CW)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .send (send[k]),
            .ret  (credit_gnt[k]),
            .cnt  (credit_cnt[k*CW +: CW]),
            .ovf  (ovf[k])
        );
    end

    // Round-robin: smallest eligible index >= ptr wins, else smallest overall.
    always_comb begin
        st_v = 1'b0;
        st_g = '0;
        rr_v = 1'b0;
        rr_g = '0;
        for (int k = VC_W - 1; k >= 0; k--) begin
            if (elig[k]) begin
                st_v = 1'b1;
                st_g = VIW'(k);
            end
            if (elig[k] && VIW'(k) < ptr) begin
                rr_v = 1'b1;
                rr_g = VIW'(k);
            end
        end
        for (int k = VC_W - 1; k >= 0; k--) begin
            if (elig[k] && VIW'(k) >= ptr) begin
                rr_v = 1'b1;
                rr_g = VIW'(k);
            end
        end
    end

    always_comb begin
        if (PKT_LOCK != 0 && locked) begin
            gnt = elig[lock_vc];
            g   = lock_vc;
        end else if (FAIR_VC_ARB != 0) begin
            gnt = rr_v;
            g   = rr_g;
        end else begin
            gnt = st_v;
            g   = st_g;
        end
        if (!rst)
            gnt = 1'b0;
    end

    // Only the granted VC's flit reaches the mux output.
    always_comb begin
        flit = '0;
        send = '0;
        for (int k = 0; k < VC_W; k++) begin
            if (g == VIW'(k)) begin
                flit    = i_d[k*FW +: FW];
                send[k] = gnt;
            end
        end
    end

    assign flit_last = flit[LP];
    assign i_b       = ~send;
    assign err_ovf   = |ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_v     <= '0;
            o_d     <= '0;
            locked  <= 1'b0;
            lock_vc <= '0;
            ptr     <= '0;
        end else begin
            o_v <= send;
            if (gnt) begin
                o_d <= flit;
                if (PKT_LOCK != 0) begin
                    locked  <= !flit_last;
                    lock_vc <= g;
                end
                if (PKT_LOCK == 0 || flit_last)
                    ptr <= (int'(g) == VC_W - 1) ? '0 : g + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_credit_vc_tx_port.sv
// Bench: two port instances (static+lock, round-robin+no-lock) checked
// every cycle against a queue-free behavioural model plus literal pins.
module tb_credit_vc_tx_port;

    localparam int VC = 2;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int FW = AW + DW + 1;
    localparam int CR = 3;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [VC-1:0]    i_v;
    logic [VC*FW-1:0] i_d;
    logic [VC-1:0]    cg [2];
    logic [VC-1:0]    ib [2];
    logic [VC-1:0]    ov [2];
    logic [FW-1:0]    od [2];
    logic [VC*CW-1:0] cc [2];
    logic             eo [2];

    credit_vc_tx_port #(
        .VC_W(VC), .A_W(AW), .D_W(DW), .CREDITS(CR),
        .FAIR_VC_ARB(0), .PKT_LOCK(1)
    ) dut_sp (
        .clk(clk), .rst(rst), .i_v(i_v), .i_d(i_d), .i_b(ib[0]),
        .o_v(ov[0]), .o_d(od[0]), .credit_gnt(cg[0]),
        .credit_cnt(cc[0]), .err_ovf(eo[0])
    );

    credit_vc_tx_port #(
        .VC_W(VC), .A_W(AW), .D_W(DW), .CREDITS(CR),
        .FAIR_VC_ARB(1), .PKT_LOCK(0)
    ) dut_rr (
        .clk(clk), .rst(rst), .i_v(i_v), .i_d(i_d), .i_b(ib[1]),
        .o_v(ov[1]), .o_d(od[1]), .credit_gnt(cg[1]),
        .credit_cnt(cc[1]), .err_ovf(eo[1])
    );

    int vec  = 0;
    int miss = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: credits per VC, current packet owner, next VC in rotation.
    int              mcnt  [2][VC];
    int              owner [2];
    int              rrp   [2];
    bit              merr  [2];
    logic [VC-1:0]   eov   [2];
    logic [FW-1:0]   eod   [2];

    function automatic bit fair(int m);
        return m == 1;
    endfunction

    function automatic bit lock(int m);
        return m == 0;
    endfunction

    function automatic int pick(int m);
        int k;
        if (owner[m] >= 0)
            return (i_v[owner[m]] && mcnt[m][owner[m]] > 0) ? owner[m] : -1;
        for (int i = 0; i < VC; i++) begin
            k = fair(m) ? (rrp[m] + i) % VC : i;
            if (i_v[k] && mcnt[m][k] > 0)
                return k;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        int g;
        int n;
        bit lst;
        if (!rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < VC; k++) mcnt[m][k] = CR;
                owner[m] = -1;
                rrp[m]   = 0;
                merr[m]  = 1'b0;
                eov[m]   = '0;
                eod[m]   = '0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                g = pick(m);
                if (g >= 0) begin
                    eov[m] = 2'b01 << g;
                    eod[m] = i_d[g*FW +: FW];
                    lst    = eod[m][FW-1];
                    if (lock(m)) owner[m] = lst ? -1 : g;
                    if (!lock(m) || lst) rrp[m] = (g + 1) % VC;
                end else begin
                    eov[m] = '0;
                end
                for (int k = 0; k < VC; k++) begin
                    n = mcnt[m][k] - ((g == k) ? 1 : 0) + (cg[m][k] ? 1 : 0);
                    if (n > CR) begin
                        n = CR;
                        merr[m] = 1'b1;
                    end
                    mcnt[m][k] = n;
                end
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [VC-1:0]    xib;
        logic [VC*CW-1:0] xcc;
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                g   = pick(m);
                xib = (g >= 0) ? ~(2'b01 << g) : '1;
                for (int k = 0; k < VC; k++) xcc[k*CW +: CW] = CW'(mcnt[m][k]);
                chk($sformatf("i_b[%0d]", m), 32'(ib[m]), 32'(xib));
                chk($sformatf("o_v[%0d]", m), 32'(ov[m]), 32'(eov[m]));
                chk($sformatf("o_d[%0d]", m), 32'(od[m]), 32'(eod[m]));
                chk($sformatf("credit_cnt[%0d]", m), 32'(cc[m]), 32'(xcc));
                chk($sformatf("err_ovf[%0d]", m), 32'(eo[m]), 32'(merr[m]));
            end
        end
    end

    function automatic logic [FW-1:0] mk(bit last, int a, int d);
        return {last, AW'(a), DW'(d)};
    endfunction

    task automatic drive(logic [VC-1:0] v, logic [FW-1:0] f0, logic [FW-1:0] f1);
        i_v = v;
        i_d[0 +: FW]  = v[0] ? f0 : 'x;
        i_d[FW +: FW] = v[1] ? f1 : 'x;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive('0, '0, '0);
        cg[0] = '0;
        cg[1] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    logic [VC-1:0] obs  [8];
    logic [VC-1:0] obs1 [8];
    logic [FW-1:0] dobs [8];
    logic [CW-1:0] cobs [8];
    logic          eobs [8];
    int            cnt01;

    initial begin
        logic [VC-1:0] v4  [6];
        logic [FW-1:0] f14 [6];
        logic [VC-1:0] v5  [6];
        logic [VC-1:0] c5  [6];
        logic [FW-1:0] r0, r1;

        // Reset then idle
        do_reset();
        @(negedge clk);
        chk("t1_ov", 32'(ov[0]), 32'h0);
        chk("t1_ib", 32'(ib[0]), 32'h3);
        chk("t1_cnt", 32'(cc[0]), 32'hF);
        chk("t1_err", 32'(eo[0]), 32'h0);
        cyc();

        // Credit exhaustion on VC0, then a single credit return
        cnt01 = 0;
        for (int i = 0; i < 8; i++) begin
            drive(2'b01, mk(1, i, 8'h40 + i), '0);
            @(negedge clk);
            obs[i] = ov[0];
            if (ov[0] == 2'b01) cnt01++;
            cyc();
        end
        chk("t2_count", 32'(cnt01), 32'd3);
        chk("t2_third", 32'(obs[3]), 32'h1);
        chk("t2_after", 32'(obs[4]), 32'h0);
        chk("t2_cnt0", 32'(cc[0][CW-1:0]), 32'h0);
        chk("t2_ib0", 32'(ib[0][0]), 32'h1);
        cnt01 = 0;
        for (int i = 0; i < 6; i++) begin
            drive(2'b01, mk(1, 9, 8'h60 + i), '0);
            cg[0] = (i == 0) ? 2'b01 : 2'b00;
            cg[1] = cg[0];
            @(negedge clk);
            obs[i] = ov[0];
            if (ov[0] == 2'b01) cnt01++;
            cyc();
        end
        chk("t2_refill_count", 32'(cnt01), 32'd1);
        chk("t2_refill_at2", 32'(obs[2]), 32'h1);

        // Fairness: credits returned in the same cycle they are spent
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, mk(1, 0, i), mk(1, 1, i));
            @(negedge clk);
            cg[0] = ~ib[0];
            cg[1] = ~ib[1];
            obs[i]  = ov[0];
            obs1[i] = ov[1];
            cyc();
        end
        cg[0] = '0;
        cg[1] = '0;
        chk("t3_rr1", 32'(obs1[1]), 32'h1);
        chk("t3_rr2", 32'(obs1[2]), 32'h2);
        chk("t3_rr3", 32'(obs1[3]), 32'h1);
        chk("t3_rr4", 32'(obs1[4]), 32'h2);
        chk("t3_sp2", 32'(obs[2]), 32'h1);
        chk("t3_sp4", 32'(obs[4]), 32'h1);

        // Packet lock with a mid-packet valid drop on VC1
        do_reset();
        v4  = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00};
        f14 = '{mk(0, 1, 8'hA1), mk(0, 1, 8'hA2), '0, mk(1, 1, 8'hA3), '0, '0};
        for (int i = 0; i < 6; i++) begin
            drive(v4[i], mk(1, 0, 8'hC0), f14[i]);
            @(negedge clk);
            obs[i]  = ov[0];
            dobs[i] = od[0];
            cyc();
        end
        chk("t4_ov1", 32'(obs[1]), 32'h2);
        chk("t4_ov2", 32'(obs[2]), 32'h2);
        chk("t4_ov3", 32'(obs[3]), 32'h0);
        chk("t4_ov4", 32'(obs[4]), 32'h2);
        chk("t4_ov5", 32'(obs[5]), 32'h1);
        chk("t4_od1", 32'(dobs[1]), 32'h01A1);
        chk("t4_od2", 32'(dobs[2]), 32'h01A2);
        chk("t4_od3", 32'(dobs[3]), 32'h01A2);
        chk("t4_od4", 32'(dobs[4]), 32'h11A3);
        chk("t4_od5", 32'(dobs[5]), 32'h10C0);

        // Simultaneous send/return, then overflow
        do_reset();
        v5 = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        c5 = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        for (int i = 0; i < 6; i++) begin
            drive(v5[i], mk(1, 2, i), '0);
            cg[0] = c5[i];
            cg[1] = c5[i];
            @(negedge clk);
            cobs[i] = cc[0][CW-1:0];
            eobs[i] = eo[0];
            cyc();
        end
        chk("t5_cnt1", 32'(cobs[1]), 32'd2);
        chk("t5_cnt2", 32'(cobs[2]), 32'd2);
        chk("t5_cnt3", 32'(cobs[3]), 32'd3);
        chk("t5_err3", 32'(eobs[3]), 32'd0);
        chk("t5_cnt4", 32'(cobs[4]), 32'd3);
        chk("t5_err4", 32'(eobs[4]), 32'd1);
        chk("t5_err5", 32'(eobs[5]), 32'd1);

        // Asynchronous reset in the middle of a locked VC1 packet
        do_reset();
        drive(2'b10, '0, mk(0, 3, 8'hB1));
        @(negedge clk);
        cyc();
        drive(2'b11, mk(1, 0, 8'hD0), mk(0, 3, 8'hB2));
        @(negedge clk);
        chk("t6_first", 32'(ov[0]), 32'h2);
        #2 rst = 1'b0;
        #1;
        chk("t6_ov_sp", 32'(ov[0]), 32'h0);
        chk("t6_ov_rr", 32'(ov[1]), 32'h0);
        chk("t6_cnt", 32'(cc[0]), 32'hF);
        chk("t6_ib", 32'(ib[0]), 32'h3);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(2'b01, mk(1, 0, 8'hD1), '0);
        @(negedge clk);
        chk("t6_ib_post", 32'(ib[0]), 32'h2);
        cyc();
        @(negedge clk);
        chk("t6_vc0", 32'(ov[0]), 32'h1);
        cyc();

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r0 = mk($urandom_range(2) == 0, $urandom, $urandom);
            r1 = mk($urandom_range(2) == 0, $urandom, $urandom);
            drive(VC'($urandom), r0, r1);
            for (int m = 0; m < 2; m++)
                for (int k = 0; k < VC; k++)
                    cg[m][k] = (mcnt[m][k] < CR) ? ($urandom_range(1) == 1)
                                                 : ($urandom_range(150) == 0);
            if ((i % 1000) == 999) begin
                do_reset();
            end else begin
                cyc();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
